snn_mem_requester: RTL and testbench

- Clocked initiator for the accelerator memory protocol: issues read, write and timestep-advance requests; the memory block answers them.
- Loads the 3x3 filter, then runs leaky-free integrate-and-fire convolution for each output neuron and each timestep.
- Per neuron: reads its membrane potential and the 3x3 input-spike window, accumulates, writes back potential and output spike.
- Sits between the memory block and the rest of the accelerator; replaces the CSP testbench-side traffic generator.

---
 rtl/snn_mem_requester.sv | 295 +++++++++++++++++++++++++++++
 tb/tb_snn_mem_requester.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/snn_mem_requester.sv
// snn_mem_requester: memory-protocol initiator for the SNN convolution core.
// It loads the 3x3 filter, then for every timestep and every output neuron it
// reads the membrane potential (skipped at t=0) and the input-spike window,
// integrates and fires, writes the spike (when fired) and the new potential,
// and finally advances the timestep.
//
// Ports:
//   clk, reset         clock (rising edge), asynchronous active-high reset
//   start              single-cycle pulse, begins a run from IDLE or DONE
//   busy, done         run in progress / run complete
//   rd_valid/rd_ready  read request handshake; rd_type, rd_x, rd_y payload
//   rd_rvalid/rd_rdata read response (one pulse per accepted read)
//   wr_valid/wr_ready  write request handshake; wr_type, wr_x, wr_y, wr_data
//   t_valid/t_ready    timestep-advance handshake; t_value payload
module snn_mem_requester #(
    parameter int unsigned TIMESTEPS   = 10,
    parameter int unsigned F_ROWS      = 3,
    parameter int unsigned F_COLS      = 3,
    parameter int unsigned IF_ROWS     = 5,
    parameter int unsigned IF_COLS     = 5,
    parameter int unsigned F_WIDTH     = 8,
    parameter int unsigned V_POT_WIDTH = 8,
    parameter int unsigned THRESH      = 64,
    parameter int unsigned COORD_W     = 3
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    output logic                   busy,
    output logic                   done,
    output logic                   rd_valid,
    input  logic                   rd_ready,
    output logic [1:0]             rd_type,
    output logic [COORD_W-1:0]     rd_x,
    output logic [COORD_W-1:0]     rd_y,
    input  logic                   rd_rvalid,
    input  logic [7:0]             rd_rdata,
    output logic                   wr_valid,
    input  logic                   wr_ready,
    output logic                   wr_type,
    output logic [COORD_W-1:0]     wr_x,
    output logic [COORD_W-1:0]     wr_y,
    output logic [V_POT_WIDTH-1:0] wr_data,
    output logic                   t_valid,
    input  logic                   t_ready,
    output logic [7:0]             t_value
);

    localparam int unsigned OF_ROWS = IF_ROWS - F_ROWS + 1;
    localparam int unsigned OF_COLS = IF_COLS - F_COLS + 1;
    localparam int unsigned ACC_W   = V_POT_WIDTH + 4;
    localparam int unsigned F_N     = F_ROWS * F_COLS;
    localparam int unsigned K_W     = $clog2(F_N);
    localparam int unsigned V_MAX   = (1 << V_POT_WIDTH) - 1;

    localparam logic [COORD_W-1:0] FI_LAST = COORD_W'(F_ROWS - 1);
    localparam logic [COORD_W-1:0] FJ_LAST = COORD_W'(F_COLS - 1);
    localparam logic [COORD_W-1:0] OI_LAST = COORD_W'(OF_ROWS - 1);
    localparam logic [COORD_W-1:0] OJ_LAST = COORD_W'(OF_COLS - 1);
    localparam logic [7:0]         T_LAST  = 8'(TIMESTEPS - 1);

    localparam logic [3:0] S_IDLE      = 4'd0;
    localparam logic [3:0] S_FILT_REQ  = 4'd1;
    localparam logic [3:0] S_FILT_WAIT = 4'd2;
    localparam logic [3:0] S_NEURON    = 4'd3;
    localparam logic [3:0] S_VP_REQ    = 4'd4;
    localparam logic [3:0] S_VP_WAIT   = 4'd5;
    localparam logic [3:0] S_SP_REQ    = 4'd6;
    localparam logic [3:0] S_SP_WAIT   = 4'd7;
    localparam logic [3:0] S_EVAL      = 4'd8;
    localparam logic [3:0] S_SPK_WR    = 4'd9;
    localparam logic [3:0] S_VP_WR     = 4'd10;
    localparam logic [3:0] S_T_SEND    = 4'd11;
    localparam logic [3:0] S_DONE      = 4'd12;

    logic [3:0]             state, state_n;
    logic [COORD_W-1:0]     fi, fi_n, fj, fj_n;
    logic [K_W-1:0]         k, k_n;
    logic [COORD_W-1:0]     i, i_n, j, j_n;
    logic [7:0]             t, t_n;
    logic [ACC_W-1:0]       acc, acc_n, diff;
    logic [V_POT_WIDTH-1:0] new_pot, new_pot_n;
    logic [F_WIDTH-1:0]     filt [F_N];
    logic                   filt_we;

    logic                   rd_xfer, wr_xfer, t_xfer, last_win;
    logic                   rd_req_n, wr_req_n;
    logic                   busy_n, done_n, rd_valid_n, wr_valid_n, t_valid_n, wr_type_n;
    logic [1:0]             rd_type_n;
    logic [COORD_W-1:0]     rd_x_n, rd_y_n, wr_x_n, wr_y_n;
    logic [V_POT_WIDTH-1:0] wr_data_n;
    logic [7:0]             t_value_n;

    // Transfers are qualified by the registered valids actually on the bus.
    assign rd_xfer  = rd_valid && rd_ready;
    assign wr_xfer  = wr_valid && wr_ready;
    assign t_xfer   = t_valid && t_ready;
    assign last_win = (fi == FI_LAST) && (fj == FJ_LAST);

    // Next-state, datapath and next-output logic.
    always_comb begin
        state_n   = state;
        fi_n      = fi;
        fj_n      = fj;
        k_n       = k;
        i_n       = i;
        j_n       = j;
        t_n       = t;
        acc_n     = acc;
        new_pot_n = new_pot;
        diff      = '0;
        filt_we   = 1'b0;

        case (state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_n = S_FILT_REQ;
                    fi_n    = '0;
                    fj_n    = '0;
                    k_n     = '0;
                end
            end
            S_FILT_REQ: if (rd_xfer) state_n = S_FILT_WAIT;
            S_FILT_WAIT: begin
                if (rd_rvalid) begin
                    filt_we = 1'b1;
                    if (last_win) begin
                        state_n = S_NEURON;
                        t_n     = '0;
                        i_n     = '0;
                        j_n     = '0;
                    end else begin
                        state_n = S_FILT_REQ;
                        k_n     = k + K_W'(1);
                        if (fj == FJ_LAST) begin
                            fj_n = '0;
                            fi_n = fi + COORD_W'(1);
                        end else begin
                            fj_n = fj + COORD_W'(1);
                        end
                    end
                end
            end
            S_NEURON: begin
                fi_n = '0;
                fj_n = '0;
                k_n  = '0;
                // The first timestep starts from rest: no potential read.
                if (t == 8'd0) begin
                    acc_n   = '0;
                    state_n = S_SP_REQ;
                end else begin
                    state_n = S_VP_REQ;
                end
            end
            S_VP_REQ: if (rd_xfer) state_n = S_VP_WAIT;
            S_VP_WAIT: begin
                if (rd_rvalid) begin
                    acc_n   = ACC_W'(rd_rdata);
                    state_n = S_SP_REQ;
                end
            end
            S_SP_REQ: if (rd_xfer) state_n = S_SP_WAIT;
            S_SP_WAIT: begin
                if (rd_rvalid) begin
                    if (rd_rdata[0]) acc_n = acc + ACC_W'(filt[k]);
                    if (last_win) begin
                        state_n = S_EVAL;
                    end else begin
                        state_n = S_SP_REQ;
                        k_n     = k + K_W'(1);
                        if (fj == FJ_LAST) begin
                            fj_n = '0;
                            fi_n = fi + COORD_W'(1);
                        end else begin
                            fj_n = fj + COORD_W'(1);
                        end
                    end
                end
            end
            S_EVAL: begin
                if (acc >= ACC_W'(THRESH)) begin
                    diff    = acc - ACC_W'(THRESH);
                    state_n = S_SPK_WR;
                end else begin
                    diff    = acc;
                    state_n = S_VP_WR;
                end
                new_pot_n = (diff > ACC_W'(V_MAX)) ? V_POT_WIDTH'(V_MAX) : V_POT_WIDTH'(diff);
            end
            S_SPK_WR: if (wr_xfer) state_n = S_VP_WR;
            S_VP_WR: begin
                if (wr_xfer) begin
                    state_n = S_NEURON;
                    if (j == OJ_LAST) begin
                        j_n = '0;
                        if (i == OI_LAST) state_n = S_T_SEND;
                        else              i_n = i + COORD_W'(1);
                    end else begin
                        j_n = j + COORD_W'(1);
                    end
                end
            end
            S_T_SEND: begin
                if (t_xfer) begin
                    t_n = t + 8'd1;
                    i_n = '0;
                    j_n = '0;
                    state_n = (t == T_LAST) ? S_DONE : S_NEURON;
                end
            end
            default: state_n = S_IDLE;
        endcase

        // Registered outputs follow the next state; a valid always drops for
        // one cycle after its transfer, even between back-to-back writes.
        rd_req_n   = (state_n == S_FILT_REQ) || (state_n == S_VP_REQ) || (state_n == S_SP_REQ);
        wr_req_n   = (state_n == S_SPK_WR) || (state_n == S_VP_WR);
        rd_valid_n = rd_req_n && !rd_xfer;
        wr_valid_n = wr_req_n && !wr_xfer;
        t_valid_n  = (state_n == S_T_SEND) && !t_xfer;
        busy_n     = (state_n != S_IDLE) && (state_n != S_DONE);
        done_n     = (state_n == S_DONE);

        rd_type_n = 2'd0;
        rd_x_n    = '0;
        rd_y_n    = '0;
        case (state_n)
            S_FILT_REQ: begin rd_type_n = 2'd2; rd_x_n = fi_n;        rd_y_n = fj_n;        end
            S_VP_REQ:   begin rd_type_n = 2'd0; rd_x_n = i_n;         rd_y_n = j_n;         end
            S_SP_REQ:   begin rd_type_n = 2'd1; rd_x_n = i_n + fi_n;  rd_y_n = j_n + fj_n;  end
            default:    ;
        endcase

        wr_type_n = (state_n == S_SPK_WR);
        wr_x_n    = wr_req_n ? i_n : '0;
        wr_y_n    = wr_req_n ? j_n : '0;
        wr_data_n = (state_n == S_VP_WR) ? new_pot_n : '0;
        t_value_n = (state_n == S_T_SEND) ? (t_n + 8'd1) : 8'd0;
    end

    // State, datapath and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= S_IDLE;
            fi       <= '0;
            fj       <= '0;
            k        <= '0;
            i        <= '0;
            j        <= '0;
            t        <= '0;
            acc      <= '0;
            new_pot  <= '0;
            for (int n = 0; n < F_N; n++) filt[n] <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            rd_valid <= 1'b0;
            rd_type  <= '0;
            rd_x     <= '0;
            rd_y     <= '0;
            wr_valid <= 1'b0;
            wr_type  <= 1'b0;
            wr_x     <= '0;
            wr_y     <= '0;
            wr_data  <= '0;
            t_valid  <= 1'b0;
            t_value  <= '0;
        end else begin
            state    <= state_n;
            fi       <= fi_n;
            fj       <= fj_n;
            k        <= k_n;
            i        <= i_n;
            j        <= j_n;
            t        <= t_n;
            acc      <= acc_n;
            new_pot  <= new_pot_n;
            if (filt_we) filt[k] <= F_WIDTH'(rd_rdata);
            busy     <= busy_n;
            done     <= done_n;
            rd_valid <= rd_valid_n;
            rd_type  <= rd_type_n;
            rd_x     <= rd_x_n;
            rd_y     <= rd_y_n;
            wr_valid <= wr_valid_n;
            wr_type  <= wr_type_n;
            wr_x     <= wr_x_n;
            wr_y     <= wr_y_n;
            wr_data  <= wr_data_n;
            t_valid  <= t_valid_n;
            t_value  <= t_value_n;
        end
    end

endmodule

// File: tb/tb_snn_mem_requester.sv
// Bench for snn_mem_requester: a behavioural memory block answers requests
// (optional random stalls and response latency); a reference model of the
// integrate-and-fire convolution fills expected read/write/timestep queues.
module tb_snn_mem_requester;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       busy, done;
    logic       rd_valid, rd_ready = 1'b0;
    logic [1:0] rd_type;
    logic [2:0] rd_x, rd_y;
    logic       rd_rvalid = 1'b0;
    logic [7:0] rd_rdata = 8'd0;
    logic       wr_valid, wr_ready = 1'b0;
    logic       wr_type;
    logic [2:0] wr_x, wr_y;
    logic [7:0] wr_data;
    logic       t_valid, t_ready = 1'b0;
    logic [7:0] t_value;

    always #5 clk = ~clk;

    snn_mem_requester dut (
        .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_type(rd_type), .rd_x(rd_x), .rd_y(rd_y),
        .rd_rvalid(rd_rvalid), .rd_rdata(rd_rdata),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_type(wr_type), .wr_x(wr_x), .wr_y(wr_y),
        .wr_data(wr_data), .t_valid(t_valid), .t_ready(t_ready), .t_value(t_value)
    );

    // Memory contents and bench configuration.
    logic [7:0] filt_mem [8][8];
    logic       ifmap_mem [8][8];
    logic [7:0] vmem [8][8];
    bit         rand_mode = 1'b0;
    bit         hold_on = 1'b0;
    int         hold_t = 0;

    // Responder / monitor state.
    bit         pend = 1'b0, held = 1'b0;
    int         cnt = 0, tcnt = 0, stab_bad = 0, stab_stalls = 0;
    logic [7:0] pend_data = 8'd0;
    bit         prv_rd = 1'b0, prv_wr = 1'b0, prv_t = 1'b0;
    logic [7:0] prv_rd_pl = 8'd0, prv_t_pl = 8'd0;
    logic [15:0] prv_wr_pl = 16'd0;

    logic [31:0] rd_obs[$], wr_obs[$], t_obs[$];
    logic [31:0] rd_exp[$], wr_exp[$], t_exp[$];

    int n_cmp = 0, n_err = 0;

    function automatic logic [31:0] enc_rd(input int ty, input int x, input int y);
        return 32'((ty << 6) | (x << 3) | y);
    endfunction

    function automatic logic [31:0] enc_wr(input int ty, input int x, input int y, input int d);
        return 32'((ty << 14) | (x << 11) | (y << 8) | d);
    endfunction

    // Memory block: responses, stall generation, transfer capture.
    always @(negedge clk) begin
        if (!hold_on) held = 1'b0;
        rd_rvalid = 1'b0;
        rd_rdata  = 8'($urandom);
        if (pend && !held) begin
            if (cnt <= 1) begin
                rd_rvalid = 1'b1;
                rd_rdata  = pend_data;
                pend      = 1'b0;
            end else begin
                cnt--;
            end
        end

        if (reset) begin
            prv_rd = 1'b0; prv_wr = 1'b0; prv_t = 1'b0;
        end else begin
            if (prv_rd && !(rd_valid && {rd_type, rd_x, rd_y} == prv_rd_pl)) stab_bad++;
            if (prv_wr && !(wr_valid && {wr_type, wr_x, wr_y, wr_data} == prv_wr_pl[15:0])) stab_bad++;
            if (prv_t && !(t_valid && t_value == prv_t_pl)) stab_bad++;
        end

        if (rand_mode) begin
            rd_ready = ($urandom_range(0, 3) != 0);
            wr_ready = ($urandom_range(0, 3) != 0);
            t_ready  = ($urandom_range(0, 3) != 0);
        end else begin
            rd_ready = 1'b1; wr_ready = 1'b1; t_ready = 1'b1;
        end

        if (!reset) begin
            prv_rd = rd_valid && !rd_ready;
            prv_wr = wr_valid && !wr_ready;
            prv_t  = t_valid && !t_ready;
            prv_rd_pl = {rd_type, rd_x, rd_y};
            prv_wr_pl = {1'b0, wr_type, wr_x, wr_y, wr_data};
            prv_t_pl  = t_value;
            if (prv_rd || prv_wr || prv_t) stab_stalls++;
            if (rd_valid && rd_ready) begin
                rd_obs.push_back(enc_rd(int'(rd_type), int'(rd_x), int'(rd_y)));
                pend = 1'b1;
                cnt  = rand_mode ? int'($urandom_range(1, 5)) : 1;
                case (rd_type)
                    2'd0:    pend_data = vmem[rd_x][rd_y];
                    2'd1:    pend_data = {7'd0, ifmap_mem[rd_x][rd_y]};
                    2'd2:    pend_data = filt_mem[rd_x][rd_y];
                    default: pend_data = 8'd0;
                endcase
                if (hold_on && rd_type == 2'd1 && tcnt >= hold_t) held = 1'b1;
            end
            if (wr_valid && wr_ready) begin
                wr_obs.push_back(enc_wr(int'(wr_type), int'(wr_x), int'(wr_y), int'(wr_data)));
                if (!wr_type) vmem[wr_x][wr_y] = wr_data;
            end
            if (t_valid && t_ready) begin
                t_obs.push_back(32'(t_value));
                tcnt++;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_mem(input int fval, input int sval);
        for (int x = 0; x < 8; x++)
            for (int y = 0; y < 8; y++) begin
                filt_mem[x][y]  = 8'(fval);
                ifmap_mem[x][y] = 1'(sval);
            end
    endtask

    // Reference model: expected reads, writes and timestep values for a run.
    task automatic build_exp();
        int pot [3][3];
        int v;
        rd_exp.delete(); wr_exp.delete(); t_exp.delete();
        for (int fi = 0; fi < 3; fi++)
            for (int fj = 0; fj < 3; fj++) rd_exp.push_back(enc_rd(2, fi, fj));
        for (int t = 0; t < 10; t++) begin
            for (int i = 0; i < 3; i++)
                for (int j = 0; j < 3; j++) begin
                    v = 0;
                    if (t > 0) begin
                        rd_exp.push_back(enc_rd(0, i, j));
                        v = pot[i][j];
                    end
                    for (int fi = 0; fi < 3; fi++)
                        for (int fj = 0; fj < 3; fj++) begin
                            rd_exp.push_back(enc_rd(1, i + fi, j + fj));
                            if (ifmap_mem[i + fi][j + fj]) v += int'(filt_mem[fi][fj]);
                        end
                    if (v >= 64) begin
                        wr_exp.push_back(enc_wr(1, i, j, 0));
                        v -= 64;
                    end
                    if (v > 255) v = 255;
                    pot[i][j] = v;
                    wr_exp.push_back(enc_wr(0, i, j, v));
                end
            t_exp.push_back(32'(t + 1));
        end
    endtask

    task automatic start_pulse();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (!done && n < 40000) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_done_reached"}, 32'(done), 32'd1);
        chk({tag, "_busy_low"}, 32'(busy), 32'd0);
    endtask

    // Pops expected entries and compares them against observed transfers.
    task automatic compare_run(input string tag, input int rb, input int wb, input int tb);
        logic [31:0] e;
        chk({tag, "_rd_count"}, 32'(rd_obs.size() - rb), 32'(rd_exp.size()));
        chk({tag, "_wr_count"}, 32'(wr_obs.size() - wb), 32'(wr_exp.size()));
        chk({tag, "_t_count"}, 32'(t_obs.size() - tb), 32'(t_exp.size()));
        while (rd_exp.size() > 0) begin
            e = rd_exp.pop_front();
            chk({tag, "_rd"}, (rb < rd_obs.size()) ? rd_obs[rb] : 32'hFFFF_FFFF, e);
            rb++;
        end
        while (wr_exp.size() > 0) begin
            e = wr_exp.pop_front();
            chk({tag, "_wr"}, (wb < wr_obs.size()) ? wr_obs[wb] : 32'hFFFF_FFFF, e);
            wb++;
        end
        while (t_exp.size() > 0) begin
            e = t_exp.pop_front();
            chk({tag, "_t"}, (tb < t_obs.size()) ? t_obs[tb] : 32'hFFFF_FFFF, e);
            tb++;
        end
    endtask

    function automatic int count_spikes(input int wb);
        int s = 0;
        for (int n = wb; n < wr_obs.size(); n++) if (wr_obs[n][14]) s++;
        return s;
    endfunction

    initial begin
        int rb, wb, tb, n, ty0;

        set_mem(1, 1);
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_rd_valid", 32'(rd_valid), 32'd0);
        chk("rst_wr_valid", 32'(wr_valid), 32'd0);
        chk("rst_t_valid", 32'(t_valid), 32'd0);
        chk("rst_payload", {rd_type, rd_x, rd_y, wr_type, wr_x, wr_y, wr_data, t_value}, 32'd0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Zero-wait run, filter 1 / ifmap 1, with a start pulse while busy.
        build_exp();
        rb = rd_obs.size(); wb = wr_obs.size(); tb = t_obs.size();
        start_pulse();
        chk("a_busy_after_start", 32'(busy), 32'd1);
        repeat (40) @(negedge clk);
        start_pulse();
        wait_done("a");
        chk("a_spikes", 32'(count_spikes(wb)), 32'd9);
        if (wr_obs.size() >= wb + 64)
            chk("a_first_spike_t7", wr_obs[wb + 63], enc_wr(1, 0, 0, 0));
        compare_run("a", rb, wb, tb);

        // Restart from DONE with random stalls and response latency.
        rand_mode = 1'b1;
        build_exp();
        rb = rd_obs.size(); wb = wr_obs.size(); tb = t_obs.size();
        start_pulse();
        chk("b_done_cleared", 32'(done), 32'd0);
        chk("b_busy", 32'(busy), 32'd1);
        chk("b_first_req", {rd_valid, rd_type, rd_x, rd_y}, {1'b1, 2'd2, 3'd0, 3'd0});
        wait_done("b");
        compare_run("b", rb, wb, tb);
        chk("b_stalls_seen", 32'(stab_stalls > 0), 32'd1);
        chk("b_stall_stability", 32'(stab_bad), 32'd0);
        rand_mode = 1'b0;

        // Saturation: filter 255, ifmap 1.
        set_mem(255, 1);
        build_exp();
        rb = rd_obs.size(); wb = wr_obs.size(); tb = t_obs.size();
        start_pulse();
        wait_done("c");
        if (wr_obs.size() >= wb + 20) begin
            chk("c_t0_spike", wr_obs[wb], enc_wr(1, 0, 0, 0));
            chk("c_t0_sat", wr_obs[wb + 1], enc_wr(0, 0, 0, 255));
            chk("c_t1_sat", wr_obs[wb + 19], enc_wr(0, 0, 0, 255));
        end
        compare_run("c", rb, wb, tb);

        // Silent input: no spikes, no potential reads at t=0.
        set_mem(1, 0);
        build_exp();
        rb = rd_obs.size(); wb = wr_obs.size(); tb = t_obs.size();
        start_pulse();
        wait_done("d");
        chk("d_spikes", 32'(count_spikes(wb)), 32'd0);
        ty0 = 0;
        for (n = rb; n < rd_obs.size() && n < rb + 90; n++) if (rd_obs[n][7:6] == 2'd0) ty0++;
        chk("d_t0_no_vp_reads", 32'(ty0), 32'd0);
        compare_run("d", rb, wb, tb);

        // Reset while waiting for a spike read at t=3; late response ignored.
        set_mem(1, 1);
        hold_t  = tcnt + 3;
        hold_on = 1'b1;
        start_pulse();
        n = 0;
        while (!held && n < 20000) begin
            @(negedge clk);
            n++;
        end
        chk("e_held_in_sp_wait", 32'(held), 32'd1);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("e_rst_outputs", {busy, done, rd_valid, wr_valid, t_valid, t_value}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        rb = rd_obs.size();
        @(negedge clk);
        hold_on = 1'b0;
        repeat (10) @(negedge clk);
        chk("e_idle_after_late_rvalid", {busy, done, rd_valid, wr_valid, t_valid}, 32'd0);
        chk("e_no_reads_after_reset", 32'(rd_obs.size() - rb), 32'd0);
        build_exp();
        rb = rd_obs.size(); wb = wr_obs.size(); tb = t_obs.size();
        start_pulse();
        chk("e_restart_filter_req", {rd_valid, rd_type, rd_x, rd_y}, {1'b1, 2'd2, 3'd0, 3'd0});
        wait_done("e");
        compare_run("e", rb, wb, tb);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
